// File: rtl/pixel_filter_ctrl_if.sv
// Pixel stream, sync, control and status bundle for pixel_filter_ctrl.
// The master drives the video/control inputs; the slave is the filter block.
interface pixel_filter_ctrl_if;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        hsync_in;
  logic        vsync_in;
  logic        frame_start;
  logic        btn_next;
  logic [3:0]  thr_level;
  logic [11:0] pix_out;
  logic        pix_valid_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [1:0]  mode_active;
  logic [1:0]  mode_pending;
  logic        change_pending;

  modport master (
    output pix_in, pix_valid, hsync_in, vsync_in, frame_start, btn_next, thr_level,
    input  pix_out, pix_valid_out, hsync_out, vsync_out, mode_active, mode_pending, change_pending
  );

  modport slave (
    input  pix_in, pix_valid, hsync_in, vsync_in, frame_start, btn_next, thr_level,
    output pix_out, pix_valid_out, hsync_out, vsync_out, mode_active, mode_pending, change_pending
  );
endinterface

// File: rtl/pixel_filter_ctrl.sv
// RGB444 pixel filter (bypass/greyscale/invert/threshold) with frame-synchronous mode switching.
// Define PIXEL_FILTER_INVERT_EN to include the invert mode; otherwise modes cycle 0->1->3.
module pixel_filter_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  pixel_filter_ctrl_if.slave   bus
);

  localparam logic [1:0] MODE_GREY   = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd3;
`ifdef PIXEL_FILTER_INVERT_EN
  localparam logic [1:0] MODE_INVERT = 2'd2;
`endif

  typedef enum logic {STABLE, PENDING} state_t;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
`ifdef PIXEL_FILTER_INVERT_EN
    return m + 2'd1;
`else
    case (m)
      2'd0:      return MODE_GREY;
      MODE_GREY: return MODE_THRESH;
      default:   return 2'd0;
    endcase
`endif
  endfunction

  state_t      state, state_nxt;
  logic [1:0]  active_q, active_d;
  logic [1:0]  pending_q, pending_d;
  logic [3:0]  thr_q, thr_d;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    active_d  = active_q;
    pending_d = pending_q;
    thr_d     = thr_q;
    if (bus.frame_start) thr_d = bus.thr_level;
    case (state)
      STABLE: begin
        if (bus.btn_next && bus.frame_start) begin
          active_d  = next_mode(active_q);
          pending_d = next_mode(active_q);
        end else if (bus.btn_next) begin
          pending_d = next_mode(active_q);
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (bus.frame_start) begin
          active_d = pending_q;
          // A press coinciding with the commit starts a new pending change from the committed mode.
          if (bus.btn_next) pending_d = next_mode(pending_q);
          else              state_nxt = STABLE;
        end else if (bus.btn_next) begin
          pending_d = next_mode(pending_q);
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STABLE;
      active_q  <= 2'd0;
      pending_q <= 2'd0;
      thr_q     <= 4'd0;
    end else begin
      state     <= state_nxt;
      active_q  <= active_d;
      pending_q <= pending_d;
      thr_q     <= thr_d;
    end
  end

  // Stage 1 captures the mode in force this cycle, so a frame_start-cycle pixel keeps the old mode.
  logic [11:0] s1_pix;
  logic        s1_valid, s1_hs, s1_vs;
  logic [1:0]  s1_mode;
  logic [3:0]  s1_thr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_pix   <= 12'h000;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_mode  <= 2'd0;
      s1_thr   <= 4'd0;
    end else begin
      s1_pix   <= bus.pix_in;
      s1_valid <= bus.pix_valid;
      s1_hs    <= bus.hsync_in;
      s1_vs    <= bus.vsync_in;
      s1_mode  <= active_q;
      s1_thr   <= thr_q;
    end
  end

  logic [8:0]  grey9;
  logic [3:0]  g4;
  logic [11:0] filt;

  assign grey9 = {1'b0, s1_pix[7:4], 4'b0000} + {3'b000, s1_pix[11:9], 3'b000}
               + {5'b00000, s1_pix[3:0]};
  assign g4    = grey9[8] ? 4'hF : grey9[7:4];

  always_comb begin
    filt = s1_pix;
    case (s1_mode)
      MODE_GREY:   filt = {g4, g4, g4};
`ifdef PIXEL_FILTER_INVERT_EN
      MODE_INVERT: filt = ~s1_pix;
`endif
      MODE_THRESH: filt = (g4 >= s1_thr) ? 12'hFFF : 12'h000;
      default:     filt = s1_pix;
    endcase
  end

  logic [11:0] s2_pix;
  logic        s2_valid, s2_hs, s2_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_pix   <= 12'h000;
      s2_valid <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
    end else begin
      s2_pix   <= s1_valid ? filt : 12'h000;
      s2_valid <= s1_valid;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  assign bus.pix_out        = s2_pix;
  assign bus.pix_valid_out  = s2_valid;
  assign bus.hsync_out      = s2_hs;
  assign bus.vsync_out      = s2_vs;
  assign bus.mode_active    = active_q;
  assign bus.mode_pending   = pending_q;
  assign bus.change_pending = (state == PENDING);

endmodule
